// File: rtl/piano_key_tracker.sv
// piano_key_tracker
//   Consumes debounced key levels and produces
//   (a) a registered "active note" with last-pressed-wins priority, and
//   (b) a FIFO-buffered stream of press/release events, lowest key index first.
//   Each key has one pending bit. An unreported change on that key is remembered
//   there and serviced once the FIFO has room, so no change is ever dropped.
//   A change that is undone before it is serviced produces no event.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset. Release is assumed to be
//                synchronized to clk upstream.
//   keys_db      debounced key levels, 1 = pressed, synchronous to clk
//   note_valid   at least one key held and an active note defined
//   note_idx     active note index (0 when note_valid = 0)
//   evt_valid    FIFO head holds an event (show-ahead)
//   evt_ready    consumer takes the head event on evt_valid & evt_ready
//   evt_press    head event type, 1 = press (0 when empty)
//   evt_idx      head event key index (0 when empty)
//   fifo_level   FIFO occupancy, 0..FIFO_DEPTH
module piano_key_tracker #(
  parameter int NUM_KEYS   = 12,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           keys_db,
  output logic                          note_valid,
  output logic [IDX_W-1:0]              note_idx,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_press,
  output logic [IDX_W-1:0]              evt_idx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Lowest set bit of a key vector, as a zero-extended index.
  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_KEYS-1:0] v);
    lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) lowest = IDX_W'(i);
  endfunction

  logic [NUM_KEYS-1:0] keys_q, pend;
  logic [NUM_KEYS-1:0] key_edge, press_edge, release_edge, svc;
  logic [PTR_W-1:0]    wptr, rptr;
  logic [PTR_W:0]      count;
  logic [IDX_W:0]      mem [FIFO_DEPTH];
  logic                wr, rd, rel_hit;

  assign key_edge     = keys_db ^ keys_q;
  assign press_edge   = key_edge & keys_db;
  assign release_edge = key_edge & ~keys_db;

  // A full FIFO blocks the write even when a read happens in the same cycle.
  assign wr = (|pend) && (count != (PTR_W+1)'(FIFO_DEPTH));
  assign rd = (count != '0) && evt_ready;

  // Isolate the lowest pending bit (two's-complement trick).
  assign svc = wr ? (pend & (~pend + NUM_KEYS'(1))) : '0;

  // Is the currently active note among this cycle's releases?
  always_comb begin
    rel_hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (release_edge[i] && note_idx == IDX_W'(i)) rel_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q     <= '0;
      pend       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      note_valid <= 1'b0;
      note_idx   <= '0;
    end else begin
      keys_q <= keys_db;
      // XOR with the edge: a second edge before service cancels the first.
      // An edge on the key being serviced this cycle re-arms its bit.
      pend   <= (pend & ~svc) ^ key_edge;

      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (|press_edge) begin
        note_valid <= 1'b1;
        note_idx   <= lowest(press_edge);
      end else if (note_valid && rel_hit) begin
        if (|keys_db) begin
          note_idx <= lowest(keys_db);
        end else begin
          note_valid <= 1'b0;
          note_idx   <= '0;
        end
      end
    end
  end

  // Storage needs no reset: the outputs are gated by occupancy.
  // The event carries keys_q, the level the pending bit refers to.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {|(keys_q & svc), lowest(pend)};
  end

  assign evt_valid  = (count != '0);
  assign evt_press  = evt_valid & mem[rptr][IDX_W];
  assign evt_idx    = evt_valid ? mem[rptr][IDX_W-1:0] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_piano_key_tracker.sv
module tb_piano_key_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] keys_db;
  logic        note_valid, evt_valid, evt_ready, evt_press;
  logic [3:0]  note_idx, evt_idx;
  logic [3:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [11:0]     keys;
    logic            v;
    logic [3:0]      idx;
    int              n;
    logic [2:0][4:0] ev;   // ev[0] expected first
  } row_t;
  row_t rows[13];

  piano_key_tracker #(.NUM_KEYS(12), .IDX_W(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .keys_db(keys_db),
    .note_valid(note_valid), .note_idx(note_idx),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_press(evt_press), .evt_idx(evt_idx), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4:0] ev_p(input int i); return {1'b1, 4'(i)}; endfunction
  function automatic logic [4:0] ev_r(input int i); return {1'b0, 4'(i)}; endfunction

  // Scoreboard: inputs are stable from negedge until the next posedge,
  // so a handshake seen here is the one that completes at that posedge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {27'd0, evt_press, evt_idx}, 32'h3ff);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("event", {27'd0, evt_press, evt_idx}, {27'd0, e});
      end
    end
  end

  task automatic drain(input string name);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_level == 0) break;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0]  = '{12'h000, 1'b0, 4'd0, 1, {5'd0,  5'd0,   ev_r(0)}};
    rows[1]  = '{12'h008, 1'b1, 4'd3, 1, {5'd0,  5'd0,   ev_p(3)}};
    rows[2]  = '{12'h088, 1'b1, 4'd7, 1, {5'd0,  5'd0,   ev_p(7)}};
    rows[3]  = '{12'h008, 1'b1, 4'd3, 1, {5'd0,  5'd0,   ev_r(7)}};
    rows[4]  = '{12'h000, 1'b0, 4'd0, 1, {5'd0,  5'd0,   ev_r(3)}};
    rows[5]  = '{12'h0A4, 1'b1, 4'd2, 3, {ev_p(7), ev_p(5), ev_p(2)}};
    rows[6]  = '{12'h0A0, 1'b1, 4'd5, 1, {5'd0,  5'd0,   ev_r(2)}};
    rows[7]  = '{12'h020, 1'b1, 4'd5, 1, {5'd0,  5'd0,   ev_r(7)}};
    rows[8]  = '{12'h040, 1'b1, 4'd6, 2, {5'd0,  ev_p(6), ev_r(5)}};
    rows[9]  = '{12'h002, 1'b1, 4'd1, 2, {5'd0,  ev_r(6), ev_p(1)}};
    rows[10] = '{12'h042, 1'b1, 4'd6, 1, {5'd0,  5'd0,   ev_p(6)}};
    rows[11] = '{12'h202, 1'b1, 4'd9, 2, {5'd0,  ev_p(9), ev_r(6)}};
    rows[12] = '{12'h000, 1'b0, 4'd0, 2, {5'd0,  ev_r(9), ev_r(1)}};

    rst_n = 1'b0; keys_db = '0; evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {note_valid, note_idx, evt_valid, evt_press, evt_idx, fifo_level}, 0);

    // Key held across reset release.
    @(posedge clk); #1;
    keys_db = 12'h001; rst_n = 1'b1;
    exp_q.push_back(ev_p(0));
    @(posedge clk); @(negedge clk);
    chk("t0_note", {note_valid, note_idx}, {1'b1, 4'd0});
    chk("t0_evt_valid", evt_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("t1_evt", {evt_valid, evt_press, evt_idx}, {1'b1, 1'b1, 4'd0});
    drain("drain_reset_press");

    for (int r = 0; r < 13; r++) begin
      @(posedge clk); #1;
      keys_db = rows[r].keys;
      for (int e = 0; e < rows[r].n; e++) exp_q.push_back(rows[r].ev[e]);
      @(posedge clk); @(negedge clk);
      chk($sformatf("note_row%0d", r), {note_valid, note_idx}, {rows[r].v, rows[r].idx});
      drain($sformatf("drain_row%0d", r));
    end

    // Backpressure: ten presses into an 8-deep FIFO.
    @(posedge clk); #1 evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      keys_db[i] = 1'b1;
      exp_q.push_back(ev_p(i));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_level", fifo_level, 8);
    chk("full_head", {evt_valid, evt_press, evt_idx}, {1'b1, 1'b1, 4'd0});
    chk("full_note", {note_valid, note_idx}, {1'b1, 4'd9});

    // Undo changes while blocked: no events for keys 4 and 10.
    @(posedge clk); #1;
    keys_db[4] = 1'b0; keys_db[10] = 1'b1;
    @(posedge clk); #1;
    keys_db[4] = 1'b1; keys_db[10] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_hold_level", fifo_level, 8);
    chk("toggle_note", {note_valid, note_idx}, {1'b1, 4'd4});

    @(posedge clk); #1 evt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("full_first_read_level", fifo_level, 7);
    @(posedge clk); @(negedge clk);
    chk("full_rd_wr_level", fifo_level, 7);
    drain("drain_full");
    repeat (6) @(negedge clk);
    chk("no_toggle_event", {evt_valid, fifo_level}, 0);

    // Mid-operation reset discards everything at once.
    @(posedge clk); #1;
    evt_ready = 1'b0; keys_db = 12'h0F0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outs",
           {note_valid, note_idx, evt_valid, evt_press, evt_idx, fifo_level}, 0);
    keys_db = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; evt_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", {evt_valid, fifo_level, note_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
